// File: rtl/ip4_rtl_pkg.sv
// Shared types and constants for the ip4 shared-memory access path.
// Used by the controller, its bank selector and the bus interface.
package ip4_rtl_pkg;

    localparam int NUM_SM_LANE = 4;
    localparam int NUM_SM_BANK = 4;
    localparam int WID_SM_BANK = $clog2(NUM_SM_BANK);

    localparam int WID_WORD    = 32;
    localparam int WID_SM_ADR  = 8;

    typedef logic [WID_WORD-1:0]   word;
    typedef logic [WID_SM_ADR-1:0] smadr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } sm_ctl_state_e;

endpackage

// File: rtl/ip4_sm_ctl_if.sv
// Request, bank and response signals of the shared-memory controller.
// The slave modport is the controller; the master modport is its
// environment (requester on one side, memory banks on the other).
interface ip4_sm_ctl_if
    import ip4_rtl_pkg::*;
#(
    parameter int NUM_LANE = NUM_SM_LANE,
    parameter int NUM_BANK = NUM_SM_BANK
);

    logic                  req_vld;
    logic                  req_rdy;
    logic                  req_wr;
    logic [NUM_LANE-1:0]   req_en;
    smadr_t [NUM_LANE-1:0] req_adr;
    word [NUM_LANE-1:0]    req_dat;

    logic [NUM_BANK-1:0]   bk_wen;
    smadr_t [NUM_BANK-1:0] bk_adr;
    word [NUM_BANK-1:0]    bk_dati;
    word [NUM_BANK-1:0]    bk_dato;

    logic                  rsp_vld;
    logic                  rsp_rdy;
    logic [NUM_LANE-1:0]   rsp_en;
    word [NUM_LANE-1:0]    rsp_dat;

    modport master (
        output req_vld, req_wr, req_en, req_adr, req_dat,
        input  req_rdy,
        input  bk_wen, bk_adr, bk_dati,
        output bk_dato,
        input  rsp_vld, rsp_en, rsp_dat,
        output rsp_rdy
    );

    modport slave (
        input  req_vld, req_wr, req_en, req_adr, req_dat,
        output req_rdy,
        output bk_wen, bk_adr, bk_dati,
        input  bk_dato,
        output rsp_vld, rsp_en, rsp_dat,
        input  rsp_rdy
    );

endinterface

// File: rtl/ip4_sm_bk_sel.sv
// Per-bank arbiter for the shared-memory controller (combinational).
// Picks the lowest-index pending lane that maps to this bank and reports
// which lanes that slot serves: every pending lane with the same address
// for loads (broadcast), only the winner itself for stores.
module ip4_sm_bk_sel
    import ip4_rtl_pkg::*;
#(
    parameter int NUM_LANE = NUM_SM_LANE,
    parameter int NUM_BANK = NUM_SM_BANK,
    parameter int BANK_IDX = 0,
    parameter int WID_LN   = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1
) (
    input  logic [NUM_LANE-1:0]   i_pend,
    input  logic                  i_wr,
    input  smadr_t [NUM_LANE-1:0] i_adr,
    output logic [WID_LN-1:0]     o_win_idx,
    output logic                  o_win_vld,
    output logic [NUM_LANE-1:0]   o_srv
);

    localparam int WID_BK = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
    localparam logic [WID_BK-1:0] BANK_SEL = WID_BK'(BANK_IDX);

    logic [NUM_LANE-1:0] w_hit;
    logic [WID_LN-1:0]   w_win_idx;
    logic                w_win_vld;
    logic [NUM_LANE-1:0] w_srv;

    // Lanes that are still pending and whose low address bits select this bank.
    always_comb begin
        w_hit = '0;
        for (int l = 0; l < NUM_LANE; l++) begin
            if (NUM_BANK == 1) begin
                w_hit[l] = i_pend[l];
            end else begin
                w_hit[l] = i_pend[l] && (i_adr[l][WID_BK-1:0] == BANK_SEL);
            end
        end
    end

    // Lowest-index hit wins (scan from the top so the lowest one is kept),
    // then build the served mask from the winner's address.
    always_comb begin
        w_win_idx = '0;
        w_win_vld = 1'b0;
        w_srv     = '0;
        for (int l = NUM_LANE - 1; l >= 0; l--) begin
            if (w_hit[l]) begin
                w_win_vld = 1'b1;
                w_win_idx = WID_LN'(l);
            end
        end
        if (w_win_vld) begin
            if (i_wr) begin
                w_srv[w_win_idx] = 1'b1;
            end else begin
                for (int l = 0; l < NUM_LANE; l++) begin
                    if (i_pend[l] && (i_adr[l] == i_adr[w_win_idx])) begin
                        w_srv[l] = 1'b1;
                    end
                end
            end
        end
    end

    assign o_win_idx = w_win_idx;
    assign o_win_vld = w_win_vld;
    assign o_srv     = w_srv;

endmodule

// File: rtl/ip4_sm_ctl.sv
// Shared-memory access controller. Accepts one multi-lane load/store per
// handshake, spreads the lanes over interleaved banks, serialises bank
// conflicts over several ISSUE cycles, broadcasts same-address loads and
// returns the collected per-lane read data on a valid/ready response.
module ip4_sm_ctl
    import ip4_rtl_pkg::*;
#(
    parameter int NUM_LANE = NUM_SM_LANE,
    parameter int NUM_BANK = NUM_SM_BANK
) (
    input  logic          clk,
    input  logic          rst_n,
    ip4_sm_ctl_if.slave   sm
);

    localparam int WID_LN = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;

    sm_ctl_state_e         r_state;
    sm_ctl_state_e         w_state_nxt;

    // Request captured at acceptance; only meaningful between IDLE and RESP.
    logic                  r_wr;
    smadr_t [NUM_LANE-1:0] r_adr;
    word [NUM_LANE-1:0]    r_dat;

    logic [NUM_LANE-1:0]   r_en;
    logic [NUM_LANE-1:0]   r_pend;
    logic [NUM_LANE-1:0]   r_iss_q [NUM_BANK];
    word [NUM_LANE-1:0]    r_rsp_dat;

    logic [WID_LN-1:0]     w_win_idx [NUM_BANK];
    logic                  w_win_vld [NUM_BANK];
    logic [NUM_LANE-1:0]   w_srv     [NUM_BANK];
    logic [NUM_LANE-1:0]   w_srv_all;
    logic [NUM_LANE-1:0]   w_pend_nxt;

    logic                  w_req_rdy;
    logic                  w_rsp_vld;
    logic                  w_accept;
    logic                  w_issue;

    logic [NUM_BANK-1:0]   w_bk_wen;
    smadr_t [NUM_BANK-1:0] w_bk_adr;
    word [NUM_BANK-1:0]    w_bk_dati;

    genvar gb;
    generate
        for (gb = 0; gb < NUM_BANK; gb++) begin : g_sel
            ip4_sm_bk_sel #(
                .NUM_LANE (NUM_LANE),
                .NUM_BANK (NUM_BANK),
                .BANK_IDX (gb),
                .WID_LN   (WID_LN)
            ) u_sel (
                .i_pend    (r_pend),
                .i_wr      (r_wr),
                .i_adr     (r_adr),
                .o_win_idx (w_win_idx[gb]),
                .o_win_vld (w_win_vld[gb]),
                .o_srv     (w_srv[gb])
            );
        end
    endgenerate

    assign w_issue  = (r_state == ISSUE);
    assign w_accept = w_req_rdy && sm.req_vld;

    // Lanes served by any bank this cycle leave the pending set.
    always_comb begin
        w_srv_all = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            w_srv_all = w_srv_all | w_srv[b];
        end
    end

    assign w_pend_nxt = r_pend & ~w_srv_all;

    // Next-state and handshake outputs. An empty lane mask still takes one
    // ISSUE cycle because the exit test looks at the post-issue pending set.
    always_comb begin
        w_state_nxt = r_state;
        w_req_rdy   = 1'b0;
        w_rsp_vld   = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_rdy = 1'b1;
                if (sm.req_vld) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (w_pend_nxt == '0) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                w_rsp_vld = 1'b1;
                if (sm.rsp_rdy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request payload; not reset since it is only read while a request is held.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_wr  <= sm.req_wr;
            r_adr <= sm.req_adr;
            r_dat <= sm.req_dat;
        end
    end

    // Pending lanes, per-bank issued masks and response collection. Read data
    // arrives one cycle after issue, so the registered issue mask steers it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en      <= '0;
            r_pend    <= '0;
            r_rsp_dat <= '0;
            for (int b = 0; b < NUM_BANK; b++) begin
                r_iss_q[b] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_en      <= sm.req_en;
                r_pend    <= sm.req_en;
                r_rsp_dat <= '0;
            end else if (w_issue) begin
                r_pend <= w_pend_nxt;
            end

            for (int b = 0; b < NUM_BANK; b++) begin
                r_iss_q[b] <= w_issue ? w_srv[b] : '0;
            end

            if (!r_wr) begin
                for (int b = 0; b < NUM_BANK; b++) begin
                    for (int l = 0; l < NUM_LANE; l++) begin
                        if (r_iss_q[b][l]) begin
                            r_rsp_dat[l] <= sm.bk_dato[b];
                        end
                    end
                end
            end
        end
    end

    // Bank drive comes straight from the winner of each bank; idle banks and
    // non-ISSUE states present all zeros.
    always_comb begin
        w_bk_wen  = '0;
        w_bk_adr  = '0;
        w_bk_dati = '0;
        if (w_issue) begin
            for (int b = 0; b < NUM_BANK; b++) begin
                if (w_win_vld[b]) begin
                    w_bk_wen[b]  = r_wr;
                    w_bk_adr[b]  = r_adr[w_win_idx[b]];
                    w_bk_dati[b] = r_dat[w_win_idx[b]];
                end
            end
        end
    end

    assign sm.req_rdy = w_req_rdy;
    assign sm.rsp_vld = w_rsp_vld;
    assign sm.rsp_en  = r_en;
    assign sm.rsp_dat = r_rsp_dat;
    assign sm.bk_wen  = w_bk_wen;
    assign sm.bk_adr  = w_bk_adr;
    assign sm.bk_dati = w_bk_dati;

endmodule

// File: tb/tb_ip4_sm_ctl.sv
// Bench for ip4_sm_ctl: behavioural banks with one-cycle read latency,
// a reference memory that predicts load data, and a scoreboard queue of
// expected responses (lane mask, data, latency, number of bank writes).
module tb_ip4_sm_ctl;
    import ip4_rtl_pkg::*;

    localparam int NL = 4;
    localparam int NB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ip4_sm_ctl_if #(.NUM_LANE(NL), .NUM_BANK(NB)) sm ();

    ip4_sm_ctl #(.NUM_LANE(NL), .NUM_BANK(NB)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sm    (sm)
    );

    typedef struct {
        logic [NL-1:0]   en;
        word [NL-1:0]    dat;
        int              lat;
        int              nwr;
    } exp_t;

    typedef struct {
        int     bank;
        smadr_t adr;
        word    dat;
    } wr_t;

    exp_t sb [$];
    wr_t  wlog [$];

    int n_chk  = 0;
    int n_fail = 0;

    word rmem [256];

    logic              t_wr;
    logic [NL-1:0]     t_en;
    smadr_t [NL-1:0]   t_adr;
    word [NL-1:0]      t_dat;
    smadr_t [NB-1:0]   snap_adr;
    logic [NB-1:0]     snap_wen;

    function automatic word init_word(input int a);
        if (a < 4) return word'(32'h10 + a);
        if (a == 5) return 32'hAB;
        return 32'h0;
    endfunction

    // Bank model: write on wen, registered read of the presented address.
    word  bmem [256];
    logic bmem_ok = 1'b0;
    always @(posedge clk) begin
        if (!bmem_ok) begin
            for (int a = 0; a < 256; a++) bmem[a] <= init_word(a);
            bmem_ok <= 1'b1;
        end else begin
            for (int b = 0; b < NB; b++)
                if (sm.bk_wen[b]) bmem[sm.bk_adr[b]] <= sm.bk_dati[b];
        end
        for (int b = 0; b < NB; b++) sm.bk_dato[b] <= bmem[sm.bk_adr[b]];
    end

    // Log of every bank write, in issue order.
    always @(negedge clk) begin
        for (int b = 0; b < NB; b++)
            if (sm.bk_wen[b]) wlog.push_back('{b, sm.bk_adr[b], sm.bk_dati[b]});
    end

    task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue slots per bank: distinct addresses for loads, enabled lanes for stores.
    function automatic int calc_k();
        int k = 1;
        for (int b = 0; b < NB; b++) begin
            int cnt = 0;
            for (int l = 0; l < NL; l++) begin
                if (t_en[l] && (int'(t_adr[l]) % NB == b)) begin
                    if (t_wr) cnt++;
                    else begin
                        bit dup = 0;
                        for (int m = 0; m < l; m++)
                            if (t_en[m] && t_adr[m] == t_adr[l]) dup = 1;
                        if (!dup) cnt++;
                    end
                end
            end
            if (cnt > k) k = cnt;
        end
        return k;
    endfunction

    task automatic push_exp();
        exp_t e;
        e.en  = t_en;
        e.dat = '0;
        e.lat = calc_k() + 2;
        e.nwr = 0;
        for (int l = 0; l < NL; l++) begin
            if (t_en[l]) begin
                if (t_wr) begin
                    rmem[t_adr[l]] = t_dat[l];
                    e.nwr++;
                end else begin
                    e.dat[l] = rmem[t_adr[l]];
                end
            end
        end
        sb.push_back(e);
    endtask

    task automatic drive_req(input bit rdy);
        sm.req_vld = 1'b1;
        sm.req_wr  = t_wr;
        sm.req_en  = t_en;
        sm.req_adr = t_adr;
        sm.req_dat = t_dat;
        sm.rsp_rdy = rdy;
    endtask

    // One full transaction; hold > 0 keeps rsp_rdy low that many cycles.
    task automatic run_req(input string tag, input int hold);
        exp_t e;
        int   lat;
        int   n;
        @(negedge clk);
        drive_req(hold == 0);
        n = 0;
        while (!sm.req_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk_eq({tag, " req_rdy"}, sm.req_rdy, 1'b1);
        push_exp();
        wlog.delete();
        @(negedge clk);
        sm.req_vld = 1'b0;
        snap_adr   = sm.bk_adr;
        snap_wen   = sm.bk_wen;
        lat = 1;
        while (!sm.rsp_vld && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        chk_eq({tag, " latency"}, lat, e.lat);
        chk_eq({tag, " rsp_en"}, sm.rsp_en, e.en);
        chk_eq({tag, " rsp_dat"}, sm.rsp_dat, e.dat);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk_eq({tag, " stall rsp_vld"}, sm.rsp_vld, 1'b1);
            chk_eq({tag, " stall rsp_dat"}, sm.rsp_dat, e.dat);
            chk_eq({tag, " stall req_rdy"}, sm.req_rdy, 1'b0);
        end
        sm.rsp_rdy = 1'b1;
        @(negedge clk);
        chk_eq({tag, " back to idle"}, sm.req_rdy, 1'b1);
        chk_eq({tag, " bank writes"}, wlog.size(), e.nwr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sm.req_vld = 1'b0;
        sm.req_wr  = 1'b0;
        sm.req_en  = '0;
        sm.req_adr = '0;
        sm.req_dat = '0;
        sm.rsp_rdy = 1'b1;
        for (int a = 0; a < 256; a++) rmem[a] = init_word(a);

        repeat (3) @(negedge clk);
        chk_eq("reset req_rdy", sm.req_rdy, 1'b1);
        chk_eq("reset rsp_vld", sm.rsp_vld, 1'b0);
        chk_eq("reset bk_wen", sm.bk_wen, '0);
        chk_eq("reset rsp_en", sm.rsp_en, '0);
        rst_n = 1'b1;

        // Reset during the second ISSUE cycle of a 4-way bank-0 store.
        t_wr  = 1'b1;
        t_en  = 4'hF;
        t_adr = {8'd28, 8'd24, 8'd20, 8'd16};
        t_dat = {32'h103, 32'h102, 32'h101, 32'h100};
        @(negedge clk);
        drive_req(1'b1);
        @(negedge clk);
        sm.req_vld = 1'b0;
        chk_eq("rst-mid first issue wen", sm.bk_wen, 4'b0001);
        chk_eq("rst-mid first issue adr", sm.bk_adr[0], 8'd16);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_eq("rst-mid bk_wen", sm.bk_wen, '0);
        chk_eq("rst-mid rsp_vld", sm.rsp_vld, 1'b0);
        chk_eq("rst-mid req_rdy", sm.req_rdy, 1'b1);
        rmem[16] = 32'h100;
        @(negedge clk);
        rst_n = 1'b1;

        // Conflict-free load, with a short response stall.
        t_wr  = 1'b0;
        t_en  = 4'hF;
        t_adr = {8'd3, 8'd2, 8'd1, 8'd0};
        run_req("load0123", 2);
        chk_eq("load0123 bank adrs", snap_adr, {8'd3, 8'd2, 8'd1, 8'd0});

        // Full conflict store to bank 0.
        t_wr  = 1'b1;
        t_en  = 4'hF;
        t_adr = {8'd12, 8'd8, 8'd4, 8'd0};
        t_dat = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        run_req("store conflict", 0);
        for (int i = 0; i < wlog.size() && i < NL; i++) begin
            chk_eq("store conflict bank", wlog[i].bank, 0);
            chk_eq("store conflict order", wlog[i].dat, t_dat[i]);
        end

        t_wr = 1'b0;
        run_req("reload conflict", 0);

        // Broadcast: all lanes read address 5.
        t_wr  = 1'b0;
        t_en  = 4'hF;
        t_adr = {8'd5, 8'd5, 8'd5, 8'd5};
        run_req("broadcast", 0);
        chk_eq("broadcast bk_adr1", snap_adr[1], 8'd5);
        chk_eq("broadcast bk_wen", snap_wen, '0);

        // Same-address store: lane order decides the final value.
        t_wr  = 1'b1;
        t_en  = 4'hF;
        t_adr = {8'd7, 8'd7, 8'd7, 8'd7};
        t_dat = {32'hD, 32'hC, 32'hB, 32'hA};
        run_req("store same", 0);
        for (int i = 0; i < wlog.size() && i < NL; i++) begin
            chk_eq("store same adr", wlog[i].adr, 8'd7);
            chk_eq("store same order", wlog[i].dat, t_dat[i]);
        end

        // Read back adr 7 plus the reset-interrupted store locations.
        t_wr  = 1'b0;
        t_en  = 4'b0111;
        t_adr = {8'd0, 8'd20, 8'd16, 8'd7};
        run_req("reload mixed", 0);

        // Empty lane mask, then a stalled response.
        t_wr  = 1'b1;
        t_en  = 4'b0000;
        t_adr = {8'd3, 8'd2, 8'd1, 8'd0};
        run_req("empty mask", 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ip4_sm_ctl.md
# ip4_sm_ctl

Shared-memory access controller sitting directly upstream of the `ip4_sm_bk` banks. It accepts one multi-lane load/store request per handshake and splits lane addresses across `NUM_BANK` interleaved banks. Bank conflicts are serialised over multiple cycles, while same-address reads are broadcast. Read data from the banks is collected into a per-lane response returned on a valid/ready handshake.

## Interface
Parameters:
- `NUM_LANE`, 4, lanes per request.
- `NUM_BANK`, 4, interleaved banks; power of two; bank index = `adr[log2(NUM_BANK)-1:0]`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_vld`  in  1  request valid.
- `req_rdy`  out  1  request ready.
- `req_wr`  in  1  1 = store, 0 = load (whole request).
- `req_en`  in  NUM_LANE  lane enable mask.
- `req_adr`  in  smadr_t[NUM_LANE]  lane word address.
- `req_dat`  in  word[NUM_LANE]  lane store data.
- `bk_wen`  out  NUM_BANK  bank write enable.
- `bk_adr`  out  smadr_t[NUM_BANK]  bank address (full address; bank ignores index bits).
- `bk_dati`  out  word[NUM_BANK]  bank write data.
- `bk_dato`  in  word[NUM_BANK]  bank read data; valid the cycle after the address is presented.
- `rsp_vld`  out  1  response valid.
- `rsp_rdy`  in  1  response ready.
- `rsp_en`  out  NUM_LANE  copy of the accepted `req_en`.
- `rsp_dat`  out  word[NUM_LANE]  load data per lane; 0 for stores and disabled lanes.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, RESP.
- IDLE
  - `req_rdy` = 1.
  - On `req_vld` && `req_rdy`: latch wr/en/adr/dat, set `pend` = `req_en`, clear `rsp_dat`, go to ISSUE.
- ISSUE, per bank b, each cycle:
  - Winner = lowest-index pending lane whose bank index = b.
  - Drive `bk_adr[b]`, `bk_dati[b]`, and `bk_wen[b]` = wr from the winner.
  - Loads: every pending lane with an address equal to the winner's is also served (broadcast).
  - Stores: no merge; each lane is issued separately, so for same-address stores the highest lane index is written last and wins.
  - Served lanes clear from `pend`; the per-bank served mask is registered as `iss_q`.
  - Go to DRAIN when the next `pend` = 0. An empty mask still spends exactly one ISSUE cycle.
- Read capture: in every cycle after an ISSUE cycle, each lane in `iss_q` loads `rsp_dat` from `bk_dato` of its bank. This applies to loads only.
- DRAIN: captures the final read, then unconditionally goes to RESP.
- RESP
  - `rsp_vld` = 1; `rsp_en`/`rsp_dat` held stable.
  - On `rsp_rdy`: go to IDLE.
- Bank outputs are combinational from registered state.
  - Outside ISSUE, and for banks with no winner: `bk_wen` = 0, `bk_adr` = 0, `bk_dati` = 0.
- Reset (asynchronous, any state):
  - State returns to IDLE; `pend`, `iss_q`, `rsp_dat` and `rsp_en` clear to 0.
  - Outputs at reset: `req_rdy` = 1, `rsp_vld` = 0, all `bk_*` = 0.
  - An in-flight request is dropped. Stores already issued remain in memory.

## Timing
- Request accepted at edge T. ISSUE occupies cycles T+1..T+k, DRAIN is T+k+1, and `rsp_vld` rises at T+k+2.
  - k = max over banks of the number of distinct issue slots: distinct addresses for loads, enabled lanes for stores.
  - k has a minimum of 1 and a maximum of `NUM_LANE`.
- Best-case latency is 3 cycles; worst case is `NUM_LANE`+2.
- No new request is accepted until the cycle after the `rsp_vld`&&`rsp_rdy` handshake; throughput is one request per k+3 cycles.
- `rsp_rdy` low stalls RESP indefinitely, with no bank activity during the stall.

## Structure
- Add to `ip4_rtl_pkg`:
  - `NUM_SM_LANE`, `NUM_SM_BANK`, `WID_SM_BANK`.
  - `sm_ctl_state_e` {IDLE, ISSUE, DRAIN, RESP}.
- Sub-module `ip4_sm_bk_sel`, instantiated `NUM_BANK` times, purely combinational:
  - Inputs: `pend`, wr, lane addresses.
  - Outputs: winner index, winner-valid, served-lane mask (broadcast for loads).

## Test plan
- Reset: assert `rst_n` low during the 2nd ISSUE cycle of a 4-conflict store. Immediately: `bk_wen` = 0, `rsp_vld` = 0, `req_rdy` = 1. After release, a new request is accepted normally.
- Conflict-free load: lanes read adr 0,1,2,3 (banks 0..3, preloaded 0x10..0x13) → one ISSUE cycle, `rsp_vld` at T+3, `rsp_dat` = {0x10,0x11,0x12,0x13}.
- Full conflict: store adr 0,4,8,12 → 4 ISSUE cycles, bank 0 only, `rsp_vld` at T+6. A subsequent load of the same addresses returns the stored data.
- Broadcast: all 4 lanes load adr 5 (value 0xAB) → single ISSUE cycle, `bk_adr[1]` = 5, all lanes 0xAB, `rsp_vld` at T+3.
- Same-address store: lanes 0..3 store A,B,C,D to adr 7 → 4 ISSUE cycles with order A,B,C,D. A later load of adr 7 returns D.
- Backpressure and empty mask: `req_en` = 0 → `rsp_vld` at T+3 with `rsp_en` = 0 and no `bk_wen`. Then hold `rsp_rdy` = 0 for 3 cycles → `rsp_vld`/`rsp_dat` stable, `req_rdy` = 0.
